// File: rtl/pipeline_sequencer_pkg.sv
// Shared types for the pipeline sequencer: FSM state encoding and the
// bundle of per-stage control signals produced by the output decoder.
package pipeline_sequencer_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_REQ  = 2'd1,
    MEM_WAIT = 2'd2
  } pipe_state_e;

  typedef struct packed {
    logic pc_en;
    logic pc_sel;
    logic if_id_en;
    logic id_ex_en;
    logic ex_lsu_en;
    logic lsu_wb_en;
    logic if_id_flush;
    logic id_ex_flush;
    logic lsu_wb_flush;
  } pipe_ctrl_t;

  // Reset: nothing loads, every stage register is bubbled.
  localparam pipe_ctrl_t CTRL_RESET  = '{pc_en: 1'b0, pc_sel: 1'b0, if_id_en: 1'b0,
                                         id_ex_en: 1'b0, ex_lsu_en: 1'b0, lsu_wb_en: 1'b0,
                                         if_id_flush: 1'b1, id_ex_flush: 1'b1,
                                         lsu_wb_flush: 1'b1};
  // Memory freeze: front end holds, a bubble drains into WB.
  localparam pipe_ctrl_t CTRL_FREEZE = '{pc_en: 1'b0, pc_sel: 1'b0, if_id_en: 1'b0,
                                         id_ex_en: 1'b0, ex_lsu_en: 1'b0, lsu_wb_en: 1'b1,
                                         if_id_flush: 1'b0, id_ex_flush: 1'b0,
                                         lsu_wb_flush: 1'b1};
  // Normal flow: everything advances.
  localparam pipe_ctrl_t CTRL_RUN    = '{pc_en: 1'b1, pc_sel: 1'b0, if_id_en: 1'b1,
                                         id_ex_en: 1'b1, ex_lsu_en: 1'b1, lsu_wb_en: 1'b1,
                                         if_id_flush: 1'b0, id_ex_flush: 1'b0,
                                         lsu_wb_flush: 1'b0};

endpackage

// File: rtl/pipeline_sequencer_if.sv
// Hazard, redirect, fetch and data-memory handshake signals between the
// pipeline sequencer (master) and the rest of the core (slave).
interface pipeline_sequencer_if #(
  parameter int CNT_W = 32
);
  logic             hazard_stall_ip;
  logic             branch_taken_ip;
  logic             instr_valid_ip;
  logic             lsu_mem_ip;
  logic             lsu_is_load_ip;
  logic             data_gnt_ip;
  logic             data_rvalid_ip;
  logic             data_req_op;
  logic             pc_en_op;
  logic             pc_sel_op;
  logic             IF_ID_en_op;
  logic             ID_EX_en_op;
  logic             EX_LSU_en_op;
  logic             LSU_WB_en_op;
  logic             IF_ID_flush_op;
  logic             ID_EX_flush_op;
  logic             LSU_WB_flush_op;
  logic [1:0]       seq_state_op;
  logic [CNT_W-1:0] stall_cnt_op;

  modport master (
    input  hazard_stall_ip, branch_taken_ip, instr_valid_ip, lsu_mem_ip,
           lsu_is_load_ip, data_gnt_ip, data_rvalid_ip,
    output data_req_op, pc_en_op, pc_sel_op, IF_ID_en_op, ID_EX_en_op,
           EX_LSU_en_op, LSU_WB_en_op, IF_ID_flush_op, ID_EX_flush_op,
           LSU_WB_flush_op, seq_state_op, stall_cnt_op
  );

  modport slave (
    output hazard_stall_ip, branch_taken_ip, instr_valid_ip, lsu_mem_ip,
           lsu_is_load_ip, data_gnt_ip, data_rvalid_ip,
    input  data_req_op, pc_en_op, pc_sel_op, IF_ID_en_op, ID_EX_en_op,
           EX_LSU_en_op, LSU_WB_en_op, IF_ID_flush_op, ID_EX_flush_op,
           LSU_WB_flush_op, seq_state_op, stall_cnt_op
  );
endinterface

// File: rtl/pipeline_sequencer_perf_counter.sv
// Free-running event counter, wraps modulo 2^W, cleared by synchronous reset.
module perf_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);
  logic [W-1:0] count_q, count_d;

  // Next count: step by one on each qualifying cycle.
  always_comb begin
    count_d = count_q;
    if (inc) count_d = count_q + W'(1);
  end

  // Count register with synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!reset) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count = count_q;
endmodule

// File: rtl/pipeline_sequencer.sv
// Central pipeline controller: merges hazard stalls, EX redirects and the
// data-memory req/gnt/rvalid handshake into per-stage enables and flushes.
// Outputs are Mealy; only the memory FSM and the stall counter hold state.
module pipeline_sequencer
  import pipeline_sequencer_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input logic                  clk,
  input logic                  reset,
  pipeline_sequencer_if.master seq
);
  pipe_state_e      state_q, state_d;
  pipe_ctrl_t       ctrl;
  logic             data_req;
  logic             frozen;
  logic [CNT_W-1:0] stall_cnt;

  // FSM state register.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (!reset) state_q <= RUN;
    else        state_q <= state_d;
  end

  // Next state, memory request, freeze detection and stage-control decode.
  // NOTE: every signal written here gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    data_req = 1'b0;
    frozen   = 1'b0;
    ctrl     = CTRL_RUN;

    unique case (state_q)
      RUN: begin
        data_req = seq.lsu_mem_ip;
        if (seq.lsu_mem_ip) begin
          if (!seq.data_gnt_ip) begin
            state_d = MEM_REQ;
            frozen  = 1'b1;
          end else if (seq.lsu_is_load_ip) begin
            state_d = MEM_WAIT;
            frozen  = 1'b1;
          end
        end
      end
      MEM_REQ: begin
        data_req = 1'b1;
        if (!seq.data_gnt_ip) begin
          frozen = 1'b1;
        end else if (seq.lsu_is_load_ip) begin
          state_d = MEM_WAIT;
          frozen  = 1'b1;
        end else begin
          state_d = RUN;
        end
      end
      MEM_WAIT: begin
        if (seq.data_rvalid_ip) state_d = RUN;
        else                    frozen  = 1'b1;
      end
      default: state_d = RUN;
    endcase

    // A held EX branch keeps asserting branch_taken, so the redirect is
    // simply taken once the freeze lifts; no redirect latch is needed.
    if (frozen) begin
      ctrl = CTRL_FREEZE;
    end else if (seq.branch_taken_ip) begin
      ctrl.pc_sel      = 1'b1;
      ctrl.if_id_flush = 1'b1;
      ctrl.id_ex_flush = 1'b1;
    end else if (seq.hazard_stall_ip) begin
      ctrl.pc_en       = 1'b0;
      ctrl.if_id_en    = 1'b0;
      ctrl.id_ex_flush = 1'b1;
    end else if (!seq.instr_valid_ip) begin
      ctrl.pc_en       = 1'b0;
      ctrl.if_id_en    = 1'b0;
      ctrl.if_id_flush = 1'b1;
    end

    if (!reset) begin
      ctrl     = CTRL_RESET;
      data_req = 1'b0;
    end
  end

  perf_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (reset & ~ctrl.if_id_en),
    .count (stall_cnt)
  );

  assign seq.data_req_op     = data_req;
  assign seq.pc_en_op        = ctrl.pc_en;
  assign seq.pc_sel_op       = ctrl.pc_sel;
  assign seq.IF_ID_en_op     = ctrl.if_id_en;
  assign seq.ID_EX_en_op     = ctrl.id_ex_en;
  assign seq.EX_LSU_en_op    = ctrl.ex_lsu_en;
  assign seq.LSU_WB_en_op    = ctrl.lsu_wb_en;
  assign seq.IF_ID_flush_op  = ctrl.if_id_flush;
  assign seq.ID_EX_flush_op  = ctrl.id_ex_flush;
  assign seq.LSU_WB_flush_op = ctrl.lsu_wb_flush;
  assign seq.seq_state_op    = state_q;
  assign seq.stall_cnt_op    = stall_cnt;
endmodule

// File: tb/tb_pipeline_sequencer.sv
// Self-checking bench for pipeline_sequencer: directed scenarios plus a
// randomized run compared against a transaction-level reference model.
module tb_pipeline_sequencer;

  // Control vector: {req, pc_en, pc_sel, if_en, id_en, ex_en, wb_en, if_fl, id_fl, wb_fl}
  typedef struct packed {
    logic req, pc_en, pc_sel, if_en, id_en, ex_en, wb_en, if_fl, id_fl, wb_fl;
  } outs_t;

  // Lower nine bits of the vector (everything except req) for each situation.
  localparam logic [8:0] C_RESET  = 9'b0_0_0000_111;
  localparam logic [8:0] C_FREEZE = 9'b0_0_0001_001;
  localparam logic [8:0] C_RUN    = 9'b1_0_1111_000;
  localparam logic [8:0] C_REDIR  = 9'b1_1_1111_110;
  localparam logic [8:0] C_HAZ    = 9'b0_0_0111_010;
  localparam logic [8:0] C_MISS   = 9'b0_0_0111_100;

  // Reference phases of the memory transaction, numbered as the state output.
  localparam int IDLE       = 0;
  localparam int AWAIT_GNT  = 1;
  localparam int AWAIT_DATA = 2;

  logic        clk;
  logic        rst;
  int          phase;
  logic [31:0] exp_cnt;
  int          tests_run;
  int          tests_failed;

  pipeline_sequencer_if #(.CNT_W(32)) sif ();

  pipeline_sequencer #(.CNT_W(32)) dut (
    .clk   (clk),
    .reset (rst),
    .seq   (sif.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic outs_t outs();
    return {sif.data_req_op, sif.pc_en_op, sif.pc_sel_op, sif.IF_ID_en_op,
            sif.ID_EX_en_op, sif.EX_LSU_en_op, sif.LSU_WB_en_op,
            sif.IF_ID_flush_op, sif.ID_EX_flush_op, sif.LSU_WB_flush_op};
  endfunction

  // Is a request on the bus this cycle, given where the transaction stands?
  function automatic logic model_req(int ph, logic mem);
    if (ph == AWAIT_DATA) return 1'b0;
    if (ph == AWAIT_GNT)  return 1'b1;
    return mem;
  endfunction

  // Expected controls from the written rules for the current inputs.
  function automatic outs_t model(int ph, logic r, logic hz, logic br, logic iv,
                                  logic mem, logic ld, logic gnt, logic rv);
    outs_t o;
    logic  request, stuck;
    o = '0;
    if (!r) begin
      o.if_fl = 1'b1; o.id_fl = 1'b1; o.wb_fl = 1'b1;
      return o;
    end
    request = model_req(ph, mem);
    stuck   = (ph == AWAIT_DATA) ? !rv : (request && (!gnt || ld));
    o.req   = request;
    if (stuck) begin
      o.wb_en = 1'b1; o.wb_fl = 1'b1;
      return o;
    end
    {o.pc_en, o.if_en, o.id_en, o.ex_en, o.wb_en} = 5'b11111;
    if (br) begin
      o.pc_sel = 1'b1; o.if_fl = 1'b1; o.id_fl = 1'b1;
    end else if (hz) begin
      o.pc_en = 1'b0; o.if_en = 1'b0; o.id_fl = 1'b1;
    end else if (!iv) begin
      o.pc_en = 1'b0; o.if_en = 1'b0; o.if_fl = 1'b1;
    end
    return o;
  endfunction

  function automatic int model_next(int ph, logic mem, logic ld, logic gnt, logic rv);
    if (ph == AWAIT_DATA) return rv ? IDLE : AWAIT_DATA;
    if (!model_req(ph, mem)) return IDLE;
    if (!gnt) return AWAIT_GNT;
    return ld ? AWAIT_DATA : IDLE;
  endfunction

  function automatic outs_t model_now();
    return model(phase, rst, sif.hazard_stall_ip, sif.branch_taken_ip, sif.instr_valid_ip,
                 sif.lsu_mem_ip, sif.lsu_is_load_ip, sif.data_gnt_ip, sif.data_rvalid_ip);
  endfunction

  // Advance one clock edge and step the reference model with the inputs seen there.
  task automatic tick();
    outs_t e;
    e = model_now();
    @(posedge clk);
    if (!rst) begin
      phase   = IDLE;
      exp_cnt = '0;
    end else begin
      if (!e.if_en) exp_cnt = exp_cnt + 32'd1;
      phase = model_next(phase, sif.lsu_mem_ip, sif.lsu_is_load_ip,
                         sif.data_gnt_ip, sif.data_rvalid_ip);
    end
    #1;
  endtask

  task automatic set_in(logic hz, logic br, logic iv, logic mem, logic ld, logic gnt, logic rv);
    sif.hazard_stall_ip = hz;
    sif.branch_taken_ip = br;
    sif.instr_valid_ip  = iv;
    sif.lsu_mem_ip      = mem;
    sif.lsu_is_load_ip  = ld;
    sif.data_gnt_ip     = gnt;
    sif.data_rvalid_ip  = rv;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    set_in(0, 0, 1, 0, 0, 0, 0);
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    set_in(1, 1, 0, 1, 1, 0, 1);
    tick();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests_run++;
      if (outs() !== {1'b0, C_RESET}) begin
        tests_failed++;
        $display("FAIL reset_ctrl c%0d got %b want %b", i, outs(), {1'b0, C_RESET});
      end
      tests_run++;
      if (sif.seq_state_op !== 2'd0 || sif.stall_cnt_op !== 32'd0) begin
        tests_failed++;
        $display("FAIL reset_state c%0d got state %0d cnt %0d want 0 0", i,
                 sif.seq_state_op, sif.stall_cnt_op);
      end
      tick();
    end
  endtask

  task automatic test_load_latency();
    do_reset();
    for (int c = 0; c < 4; c++) begin
      set_in(0, 0, 1, 1, 1, c == 0, c == 3);
      @(negedge clk);
      tests_run++;
      if (c < 3 && outs() !== {c == 0, C_FREEZE}) begin
        tests_failed++;
        $display("FAIL load_freeze c%0d got %b want %b", c, outs(), {c == 0, C_FREEZE});
      end else if (c == 3 && outs() !== {1'b0, C_RUN}) begin
        tests_failed++;
        $display("FAIL load_release got %b want %b", outs(), {1'b0, C_RUN});
      end
      tick();
    end
    set_in(0, 0, 1, 0, 0, 0, 0);
    @(negedge clk);
    tests_run++;
    if (sif.seq_state_op !== 2'd0 || sif.stall_cnt_op !== 32'd3) begin
      tests_failed++;
      $display("FAIL load_count got state %0d cnt %0d want 0 3", sif.seq_state_op, sif.stall_cnt_op);
    end
    tick();
  endtask

  task automatic test_store_gnt_delay();
    do_reset();
    for (int c = 0; c < 3; c++) begin
      set_in(0, 0, 1, 1, 0, c == 2, 0);
      @(negedge clk);
      tests_run++;
      if (outs() !== {1'b1, (c == 2) ? C_RUN : C_FREEZE} ||
          sif.seq_state_op !== ((c == 0) ? 2'd0 : 2'd1)) begin
        tests_failed++;
        $display("FAIL store_wait c%0d got %b state %0d", c, outs(), sif.seq_state_op);
      end
      tick();
    end
    set_in(0, 0, 1, 0, 0, 0, 0);
    @(negedge clk);
    tests_run++;
    if (sif.seq_state_op !== 2'd0 || sif.stall_cnt_op !== 32'd2) begin
      tests_failed++;
      $display("FAIL store_count got state %0d cnt %0d want 0 2", sif.seq_state_op, sif.stall_cnt_op);
    end
    tick();
  endtask

  task automatic test_hazard_branch();
    do_reset();
    set_in(1, 1, 1, 0, 0, 0, 0);
    @(negedge clk);
    tests_run++;
    if (outs() !== {1'b0, C_REDIR}) begin
      tests_failed++;
      $display("FAIL hazard_branch got %b want %b", outs(), {1'b0, C_REDIR});
    end
    tick();
    set_in(1, 0, 1, 0, 0, 0, 0);
    @(negedge clk);
    tests_run++;
    if (outs() !== {1'b0, C_HAZ} || sif.stall_cnt_op !== 32'd0) begin
      tests_failed++;
      $display("FAIL hazard_only got %b cnt %0d want %b cnt 0", outs(), sif.stall_cnt_op, {1'b0, C_HAZ});
    end
    tick();
    set_in(0, 0, 1, 0, 0, 0, 0);
    @(negedge clk);
    tests_run++;
    if (sif.stall_cnt_op !== 32'd1) begin
      tests_failed++;
      $display("FAIL hazard_count got %0d want 1", sif.stall_cnt_op);
    end
    tick();
  endtask

  task automatic test_branch_during_freeze();
    do_reset();
    for (int c = 0; c < 3; c++) begin
      set_in(0, 1, 1, 1, 1, c == 0, c == 2);
      @(negedge clk);
      tests_run++;
      if (outs() !== {c == 0, (c == 2) ? C_REDIR : C_FREEZE}) begin
        tests_failed++;
        $display("FAIL branch_freeze c%0d got %b want %b", c, outs(),
                 {c == 0, (c == 2) ? C_REDIR : C_FREEZE});
      end
      tick();
    end
    set_in(0, 0, 1, 0, 0, 0, 0);
    @(negedge clk);
    tests_run++;
    if (sif.seq_state_op !== 2'd0 || sif.stall_cnt_op !== 32'd2) begin
      tests_failed++;
      $display("FAIL branch_freeze_count got state %0d cnt %0d want 0 2", sif.seq_state_op, sif.stall_cnt_op);
    end
    tick();
  endtask

  task automatic test_fetch_miss();
    do_reset();
    set_in(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    tests_run++;
    if (outs() !== {1'b0, C_MISS}) begin
      tests_failed++;
      $display("FAIL fetch_miss got %b want %b", outs(), {1'b0, C_MISS});
    end
    tick();
    set_in(0, 0, 1, 0, 0, 0, 0);
    @(negedge clk);
    tests_run++;
    if (outs() !== {1'b0, C_RUN} || sif.stall_cnt_op !== 32'd1) begin
      tests_failed++;
      $display("FAIL fetch_resume got %b cnt %0d want %b cnt 1", outs(), sif.stall_cnt_op, {1'b0, C_RUN});
    end
    tick();
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    set_in(0, 0, 1, 1, 1, 1, 0);
    tick();
    set_in(0, 0, 1, 1, 1, 0, 0);
    @(negedge clk);
    tests_run++;
    if (sif.seq_state_op !== 2'd2) begin
      tests_failed++;
      $display("FAIL midwait_enter got state %0d want 2", sif.seq_state_op);
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      sif.data_rvalid_ip = i[0];
      @(negedge clk);
      tests_run++;
      if (outs() !== {1'b0, C_RESET} || sif.seq_state_op !== 2'd0 || sif.stall_cnt_op !== 32'd0) begin
        tests_failed++;
        $display("FAIL midwait_reset c%0d got %b state %0d cnt %0d", i, outs(),
                 sif.seq_state_op, sif.stall_cnt_op);
      end
    end
    tick();
    rst = 1'b1;
    set_in(0, 0, 1, 0, 0, 0, 1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      tests_run++;
      if (outs() !== {1'b0, C_RUN} || sif.seq_state_op !== 2'd0 || sif.stall_cnt_op !== 32'd0) begin
        tests_failed++;
        $display("FAIL stray_rvalid c%0d got %b state %0d cnt %0d", i, outs(),
                 sif.seq_state_op, sif.stall_cnt_op);
      end
      tick();
    end
  endtask

  task automatic test_random();
    outs_t e;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 99) != 0);
      set_in($urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 4) != 0,
             $urandom_range(0, 1) == 0, $urandom_range(0, 1) == 0, $urandom_range(0, 2) == 0,
             $urandom_range(0, 2) == 0);
      e = model_now();
      @(negedge clk);
      tests_run++;
      if (outs() !== e || sif.seq_state_op !== 2'(phase) || sif.stall_cnt_op !== exp_cnt) begin
        tests_failed++;
        $display("FAIL random c%0d got %b st %0d cnt %0d want %b st %0d cnt %0d", c, outs(),
                 sif.seq_state_op, sif.stall_cnt_op, e, phase, exp_cnt);
      end
      tick();
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    phase        = IDLE;
    exp_cnt      = '0;
    rst          = 1'b0;
    set_in(0, 0, 1, 0, 0, 0, 0);
    test_reset();
    test_load_latency();
    test_store_gnt_delay();
    test_hazard_branch();
    test_branch_during_freeze();
    test_fetch_miss();
    test_reset_mid_wait();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/pipeline_sequencer.md
# pipeline_sequencer

Central pipeline controller for the 5-stage RISC-V core. It combines three inputs into per-stage pipeline-register enables, bubble/flush controls, PC-select and the data-memory request handshake:

- the load-use/RF hazard request from the stall controller,
- the EX-stage branch/jump redirect,
- the LSU data-memory req/gnt/rvalid handshake.

It owns the only multi-cycle state in hazard handling: waiting for data-memory grant and response. It also keeps a stall-cycle performance counter.

## Interface
Parameters:
- CNT_W, 32, width of the stall-cycle counter

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-low reset
- hazard_stall_ip  in  1  load-use/RF hazard request for the instruction in ID
- branch_taken_ip  in  1  EX instruction redirects the PC
- instr_valid_ip  in  1  fetch data valid this cycle
- lsu_mem_ip  in  1  LSU-stage instruction is a load or store
- lsu_is_load_ip  in  1  LSU-stage memory op is a load
- data_gnt_ip  in  1  data memory accepted the request
- data_rvalid_ip  in  1  load data returned
- data_req_op  out  1  data-memory request
- pc_en_op  out  1  PC register update enable
- pc_sel_op  out  1  1 = branch target, 0 = PC+4
- IF_ID_en_op, ID_EX_en_op, EX_LSU_en_op, LSU_WB_en_op  out  1 each  pipeline-register load enables
- IF_ID_flush_op, ID_EX_flush_op, LSU_WB_flush_op  out  1 each  load a NOP bubble instead of upstream contents
- seq_state_op  out  2  current FSM state (pipe_state_e)
- stall_cnt_op  out  CNT_W  cycles with IF_ID_en_op = 0, wraps modulo 2^CNT_W

## Operation
- FSM states: RUN, MEM_REQ, MEM_WAIT.
- Outputs are Mealy: a function of state and current inputs. Only state and counter are registered.

Transitions:
- RUN:
  - lsu_mem_ip & !data_gnt_ip -> MEM_REQ.
  - lsu_mem_ip & data_gnt_ip & lsu_is_load_ip -> MEM_WAIT.
  - Store granted -> stays in RUN; the store completes that cycle.
- MEM_REQ:
  - data_gnt_ip & load -> MEM_WAIT.
  - data_gnt_ip & store -> RUN.
  - Otherwise hold.
- MEM_WAIT: data_rvalid_ip -> RUN, otherwise hold.

data_req_op:
- Equals lsu_mem_ip in RUN; 1 in MEM_REQ; 0 in MEM_WAIT.

Freeze:
- Active in RUN/MEM_REQ when data_req_op & !data_gnt_ip, in any load-grant cycle, and in MEM_WAIT while !data_rvalid_ip.
- Effect: pc_en, IF_ID_en, ID_EX_en, EX_LSU_en = 0; LSU_WB_en = 1 with LSU_WB_flush = 1 (bubble into WB).

Priority when not frozen:
1. Redirect (branch_taken_ip): pc_en = 1, pc_sel = 1, IF_ID_flush = 1, ID_EX_flush = 1, all enables = 1. Any hazard_stall_ip is ignored because the stalled instruction is wrong-path.
2. Hazard (hazard_stall_ip): pc_en = 0, IF_ID_en = 0, ID_EX_flush = 1; EX_LSU and LSU_WB advance.
3. Fetch miss (!instr_valid_ip): pc_en = 0, IF_ID_flush = 1; downstream advances.
4. Otherwise all enables = 1, flushes = 0, pc_sel = 0.

Freeze precedence:
- Freeze overrides redirect and hazard. branch_taken_ip stays asserted because EX is held, so no redirect latch is needed.

Counter:
- stall_cnt_op increments on every non-reset cycle where IF_ID_en_op = 0.

## Timing
Reset (reset = 0 at a rising edge):
- State goes to RUN and stall_cnt to 0 on that edge.
- While reset = 0, all enables are forced to 0, data_req_op = 0, all flushes = 1, and pc_sel = 0.
- Reset mid-MEM_WAIT abandons the outstanding load. Any rvalid in the following RUN cycles is ignored.

Latency and handshake rules:
- Store granted in the same cycle as the request: zero stall cycles.
- Load: minimum one freeze cycle. rvalid arrives no earlier than one cycle after gnt; rvalid in RUN or MEM_REQ is ignored.
- Release: in the cycle data_rvalid_ip = 1, enables are 1, LSU_WB_flush = 0, and the LSU/WB register captures the load data. State is RUN on the next edge.
- A back-to-back memory op in LSU on the cycle after release is treated as a fresh request; no idle cycle is required.

## Structure
- pipe_state_e (RUN = 2'd0, MEM_REQ = 2'd1, MEM_WAIT = 2'd2) is added to CORE_PKG.
- Sub-module perf_counter (parameter W; inputs clk, reset, inc; output count), instanced once for stall_cnt_op.
- Output decode is one always_comb block; FSM and counter are always_ff.

## Test plan
- Reset held 3 cycles during a load in MEM_WAIT -> state RUN, stall_cnt = 0, data_req_op = 0; a stray rvalid after release has no effect.
- Load with gnt at cycle 0 and rvalid at cycle 3 -> freeze on cycles 0–2, LSU_WB_flush = 1 on cycles 0–2, release at cycle 3, stall_cnt = 3.
- Store with gnt delayed 2 cycles -> state MEM_REQ for 2 cycles, data_req_op held 1, back to RUN after gnt, stall_cnt = 2.
- hazard_stall_ip and branch_taken_ip in the same cycle -> pc_sel = 1, IF_ID_flush = ID_EX_flush = 1, pc_en = 1, counter unchanged.
- branch_taken_ip during a load freeze (rvalid at +2) -> no redirect outputs while frozen; redirect outputs appear in the rvalid cycle.
- instr_valid_ip = 0 for 1 cycle in RUN -> IF_ID_flush = 1, pc_en = 0, stall_cnt += 1.
